// File: rtl/branch_sequencer.sv
// branch_sequencer: ECP8 program-counter sequencer (fetch -> issue -> execute -> next PC).
// Define BRANCH_RETSTACK_EN to add the call/return stack; the default build has no stack.
module branch_sequencer #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter int         STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_data,
    output logic       instr_valid,
    output logic [7:0] instr,
    input  logic       stall,
    input  logic       exec_done,
    input  logic       br_valid,
    input  logic [7:0] br_cond,
    input  logic [7:0] br_value,
    input  logic [7:0] br_target,
    input  logic       br_call,
    input  logic       br_ret,
    output logic [7:0] pc,
    output logic       taken,
    output logic       stack_err
);

    typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_EXEC} state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] instr_q, instr_d;
    logic       mem_req_q, mem_req_d;
    logic       instr_valid_q, instr_valid_d;
    logic       taken_q, taken_d;

    logic [7:0] pc_inc;
    logic       cond_take;
    logic       resolve;
    logic       ret_hit;
    logic [7:0] ret_pc;
    logic       unused_cond_hi;

    assign pc_inc    = pc_q + 8'd1;
    assign cond_take = br_cond[2] ^ ((br_cond[0] & (br_value == 8'h00)) | (br_cond[1] & br_value[7]));
    assign resolve   = (state_q == S_EXEC) && exec_done;
    assign unused_cond_hi = ^br_cond[7:3];

`ifdef BRANCH_RETSTACK_EN
    localparam int PTR_W = $clog2(STACK_DEPTH);

    logic [7:0]       stack_mem [STACK_DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d;    // next slot to write; wraps so a full push hits the oldest entry
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             push, pop;

    assign push    = resolve && !br_ret && br_valid && cond_take && br_call;
    assign pop     = resolve && br_ret;
    assign top_idx = sp_q - 1;
    assign ret_hit = br_ret;
    assign ret_pc  = (cnt_q == 0) ? RESET_PC : stack_mem[top_idx];

    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (push) begin
            sp_d = sp_q + 1;
            if (cnt_q == (PTR_W+1)'(STACK_DEPTH)) err_d = 1'b1;
            else                                  cnt_d = cnt_q + 1;
        end else if (pop) begin
            if (cnt_q == 0) begin
                err_d = 1'b1;
            end else begin
                sp_d  = top_idx;
                cnt_d = cnt_q - 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // NOTE: stack storage is deliberately not reset; sp_q/cnt_q decide which entries are live.
    always_ff @(posedge clk) begin
        if (rst && push) stack_mem[sp_q] <= pc_inc;
    end

    assign stack_err = err_q;
`else
    logic unused_stack;

    assign ret_hit      = 1'b0;
    assign ret_pc       = RESET_PC;
    assign stack_err    = 1'b0;
    assign unused_stack = br_call ^ br_ret ^ (STACK_DEPTH > 0);
`endif

    // NOTE: every variable gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        mem_req_d     = mem_req_q;
        instr_valid_d = instr_valid_q;
        taken_d       = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req_d = 1'b1;
                if (mem_req_q && mem_ack) begin
                    instr_d       = mem_data;
                    instr_valid_d = 1'b1;
                    mem_req_d     = 1'b0;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_EXEC;
                end
            end
            S_EXEC: begin
                if (resolve) begin
                    state_d   = S_FETCH;
                    mem_req_d = 1'b1;
                    if (ret_hit) begin
                        pc_d    = ret_pc;
                        taken_d = 1'b1;
                    end else if (br_valid && cond_take) begin
                        pc_d    = br_target;
                        taken_d = 1'b1;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: reset is synchronous and all state uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= 8'h00;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            taken_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            mem_req_q     <= mem_req_d;
            instr_valid_q <= instr_valid_d;
            taken_q       <= taken_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign taken       = taken_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: instruction memory model with same-cycle ack,
// hand-computed PC/branch expectations, return-stack steps when BRANCH_RETSTACK_EN is defined.
module tb_branch_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic       instr_valid;
    logic [7:0] instr;
    logic       stall;
    logic       exec_done;
    logic       br_valid;
    logic [7:0] br_cond;
    logic [7:0] br_value;
    logic [7:0] br_target;
    logic       br_call;
    logic       br_ret;
    logic [7:0] pc;
    logic       taken;
    logic       stack_err;

    logic [7:0] imem [256];
    logic       ack_en;
    int         cyc = 0;
    int         req_cyc = 0;
    int         t0;
    int         n_cmp = 0;
    int         n_bad = 0;

    branch_sequencer #(.RESET_PC(8'h00), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .instr_valid(instr_valid), .instr(instr), .stall(stall), .exec_done(exec_done),
        .br_valid(br_valid), .br_cond(br_cond), .br_value(br_value), .br_target(br_target),
        .br_call(br_call), .br_ret(br_ret),
        .pc(pc), .taken(taken), .stack_err(stack_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory answers in the same cycle it is asked, unless ack_en is held low.
    assign mem_ack  = mem_req && ack_en;
    assign mem_data = imem[mem_addr];

    function automatic logic [7:0] exp_byte(input logic [7:0] a);
        case (a)
            8'h00:   return 8'h11;
            8'h01:   return 8'h22;
            8'h02:   return 8'h33;
            default: return a ^ 8'h5A;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (mem_req !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, mem_req, 1);
        req_cyc = cyc;
    endtask

    // One full fetch/issue/execute loop; returns at the negedge after resolution.
    task automatic run_instr(input logic [7:0] addr, input logic bv, input logic [7:0] cond,
                             input logic [7:0] val, input logic [7:0] tgt, input logic call,
                             input logic ret, input int stall_n, input logic exp_taken,
                             input logic [7:0] exp_next, input string tag);
        wait_req(tag);
        check({tag, "_addr"}, mem_addr, addr);
        stall = (stall_n > 0);
        @(negedge clk);
        check({tag, "_valid"}, instr_valid, 1);
        check({tag, "_instr"}, instr, exp_byte(addr));
        check({tag, "_taken_low"}, taken, 0);
        for (int i = 0; i < stall_n; i++) begin
            exec_done = 1'b1;
            @(negedge clk);
            check({tag, "_hold_valid"}, instr_valid, 1);
            check({tag, "_hold_instr"}, instr, exp_byte(addr));
            check({tag, "_hold_pc"}, pc, addr);
        end
        exec_done = 1'b0;
        stall     = 1'b0;
        @(negedge clk);
        check({tag, "_exec_valid"}, instr_valid, 0);
        exec_done = 1'b1;
        br_valid  = bv;
        br_cond   = cond;
        br_value  = val;
        br_target = tgt;
        br_call   = call;
        br_ret    = ret;
        @(negedge clk);
        exec_done = 1'b0;
        br_valid  = 1'b0;
        br_call   = 1'b0;
        br_ret    = 1'b0;
        check({tag, "_taken"}, taken, exp_taken);
        check({tag, "_next_pc"}, pc, exp_next);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = exp_byte(8'(i));
        rst = 1'b0; ack_en = 1'b1; stall = 1'b0; exec_done = 1'b0;
        br_valid = 1'b0; br_cond = 8'h00; br_value = 8'h00; br_target = 8'h00;
        br_call = 1'b0; br_ret = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, 8'h00);
        check("rst_taken", taken, 0);
        check("rst_stack_err", stack_err, 0);
        check("rst_pc", pc, 8'h00);
        rst = 1'b1;

        // Straight-line fetch, 3 cycles per instruction
        run_instr(8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h01, "seq0");
        t0 = req_cyc;
        run_instr(8'h01, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h02, "seq1");
        check("gap01", req_cyc - t0, 3);
        t0 = req_cyc;
        run_instr(8'h02, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h03, "seq2");
        check("gap12", req_cyc - t0, 3);
        run_instr(8'h03, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h04, "seq3");
        run_instr(8'h04, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h05, "seq4");

        // Zero-test branches
        run_instr(8'h05, 1, 8'h01, 8'h00, 8'h40, 0, 0, 0, 1, 8'h40, "bz_take");
        run_instr(8'h40, 1, 8'h04, 8'h33, 8'h05, 0, 0, 0, 1, 8'h05, "always");
        run_instr(8'h05, 1, 8'h01, 8'h01, 8'h40, 0, 0, 0, 0, 8'h06, "bz_skip");

        // Negative test with invert, ignored high bits, never-taken
        run_instr(8'h06, 1, 8'h06, 8'h80, 8'h50, 0, 0, 0, 0, 8'h07, "inv_neg");
        run_instr(8'h07, 1, 8'h06, 8'h7F, 8'h20, 0, 0, 0, 1, 8'h20, "inv_pos");
        run_instr(8'h20, 1, 8'hF8, 8'h00, 8'h60, 0, 0, 0, 0, 8'h21, "cond_f8");
        run_instr(8'h21, 1, 8'h00, 8'h00, 8'h60, 0, 0, 0, 0, 8'h22, "cond_00");

        // Five-cycle stall, then wrap FF -> 00
        run_instr(8'h22, 1, 8'h04, 8'h00, 8'hFF, 0, 0, 5, 1, 8'hFF, "stall5");
        run_instr(8'hFF, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, "wrap");
        run_instr(8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h01, "post_wrap");

        // Reset while a fetch is outstanding; ack arrives in the reset cycle
        ack_en = 1'b0;
        wait_req("pend");
        check("pend_addr", mem_addr, 8'h01);
        @(negedge clk);
        rst    = 1'b0;
        ack_en = 1'b1;
        @(negedge clk);
        check("midrst_mem_req", mem_req, 0);
        check("midrst_pc", pc, 8'h00);
        check("midrst_instr_valid", instr_valid, 0);
        check("midrst_instr", instr, 8'h00);
        rst = 1'b1;
        run_instr(8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h01, "refetch");
        run_instr(8'h01, 1, 8'h04, 8'h00, 8'h10, 0, 0, 0, 1, 8'h10, "to10");

`ifdef BRANCH_RETSTACK_EN
        run_instr(8'h10, 1, 8'h04, 8'h00, 8'h80, 1, 0, 0, 1, 8'h80, "call80");
        run_instr(8'h80, 1, 8'h04, 8'h00, 8'h77, 1, 1, 0, 1, 8'h11, "ret11");
        check("err_after_ret", stack_err, 0);
        run_instr(8'h11, 1, 8'h04, 8'h00, 8'h30, 1, 0, 0, 1, 8'h30, "call1");
        run_instr(8'h30, 1, 8'h04, 8'h00, 8'h31, 1, 0, 0, 1, 8'h31, "call2");
        run_instr(8'h31, 1, 8'h04, 8'h00, 8'h32, 1, 0, 0, 1, 8'h32, "call3");
        run_instr(8'h32, 1, 8'h04, 8'h00, 8'h33, 1, 0, 0, 1, 8'h33, "call4");
        check("err_full", stack_err, 0);
        run_instr(8'h33, 1, 8'h04, 8'h00, 8'h34, 1, 0, 0, 1, 8'h34, "call5");
        check("err_overflow", stack_err, 1);
        run_instr(8'h34, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 1, 8'h34, "pop1");
        run_instr(8'h34, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 1, 8'h33, "pop2");
        run_instr(8'h33, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 1, 8'h32, "pop3");
        run_instr(8'h32, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 1, 8'h31, "pop4");
        run_instr(8'h31, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 1, 8'h00, "pop_empty");
        check("err_sticky", stack_err, 1);
`else
        run_instr(8'h10, 1, 8'h04, 8'h00, 8'h80, 1, 0, 0, 1, 8'h80, "call_ign");
        run_instr(8'h80, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 8'h81, "ret_ign");
        check("err_tied", stack_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
